// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment patterns, anode codes and digit codes
// Segment patterns are 7 bits {a,b,c,d,e,f,g}, active-low (0 = lit).
// Anode codes are active-low digit selects.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    localparam logic [3:0] AN_ONES      = 4'b1110;
    localparam logic [3:0] AN_TENS      = 4'b1101;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [3:0] AN_THOUSANDS = 4'b0111;
    localparam logic [3:0] AN_BLANK     = 4'b1111;

    localparam logic [3:0] DIG_DASH = 4'hA;
    localparam logic [3:0] DIG_ERR  = 4'hF;

    typedef enum logic [1:0] {
        SEL_ONES      = 2'd0,
        SEL_TENS      = 2'd1,
        SEL_HUNDREDS  = 2'd2,
        SEL_THOUSANDS = 2'd3
    } digit_sel_e;

    typedef enum logic [1:0] {
        AN_KIND_DIGIT = 2'd0,
        AN_KIND_BLANK = 2'd1,
        AN_KIND_BAD   = 2'd2
    } anode_kind_e;

    typedef struct packed {
        anode_kind_e kind;
        digit_sel_e  sel;
    } anode_info_t;

    // Classify a stable anode value: one digit selected, all off, or anything else.
    function automatic anode_info_t decode_anode(input logic [3:0] an);
        anode_info_t info;
        info.kind = AN_KIND_DIGIT;
        info.sel  = SEL_ONES;
        case (an)
            AN_ONES:      info.sel  = SEL_ONES;
            AN_TENS:      info.sel  = SEL_TENS;
            AN_HUNDREDS:  info.sel  = SEL_HUNDREDS;
            AN_THOUSANDS: info.sel  = SEL_THOUSANDS;
            AN_BLANK:     info.kind = AN_KIND_BLANK;
            default:      info.kind = AN_KIND_BAD;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// rtl/sevenseg_decode.sv - seven-segment pattern to digit code decoder
// Ports:
//   i_seg     in  7  active-low segments {a,b,c,d,e,f,g}
//   o_code    out 4  0-9 digit, DIG_DASH for a lone g segment, DIG_ERR otherwise
//   o_illegal out 1  pattern is not a recognised glyph
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_illegal
);

    always_comb begin
        o_code    = DIG_ERR;
        o_illegal = 1'b0;
        case (i_seg)
            SEG_0:    o_code = 4'd0;
            SEG_1:    o_code = 4'd1;
            SEG_2:    o_code = 4'd2;
            SEG_3:    o_code = 4'd3;
            SEG_4:    o_code = 4'd4;
            SEG_5:    o_code = 4'd5;
            SEG_6:    o_code = 4'd6;
            SEG_7:    o_code = 4'd7;
            SEG_8:    o_code = 4'd8;
            SEG_9:    o_code = 4'd9;
            SEG_DASH: o_code = DIG_DASH;
            default: begin
                o_code    = DIG_ERR;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - recovers four digits and decimal points from a scanned 7-seg bus
// Ports:
//   clk, clr (async active-low reset)
//   anode[3:0]   active-low digit select, cathode[7:0] active-low {a..g,dp}
//   ones/tens/hundreds/thousands[3:0]  decoded digit codes
//   dp[3:0]      decimal points, active-high, [0]=ones
//   frame_done   pulse when all four digits have been committed
//   seg_err      pulse on committing an illegal pattern
//   anode_err    pulse on a stable anode value that selects more than one digit
//   stale        level, no digit commit for TIMEOUT_CYCLES
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 524288
)(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] anode,
    input  logic [7:0] cathode,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] dp,
    output logic       frame_done,
    output logic       seg_err,
    output logic       anode_err,
    output logic       stale
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    logic [11:0]   r_sync1;
    logic [11:0]   r_sync2;
    logic [11:0]   r_prev;
    logic [SW-1:0] r_stab_cnt;
    logic          r_armed;
    logic [3:0]    r_digit [4];
    logic [3:0]    r_dp;
    logic [3:0]    r_seen;
    logic          r_frame_done;
    logic          r_seg_err;
    logic          r_anode_err;
    logic [TW-1:0] r_to_cnt;
    logic          r_stale;

    logic          w_changed;
    logic          w_commit;
    logic          w_digit_commit;
    anode_info_t   w_an;
    logic [3:0]    w_code;
    logic          w_illegal;
    logic [3:0]    w_seen_next;

    // r_prev holds the value that has been stable for r_stab_cnt cycles, so it is
    // the one committed even if the bus moves again in the commit cycle.
    assign w_changed      = (r_sync2 != r_prev);
    assign w_commit       = r_armed && (r_stab_cnt == STAB_MAX);
    assign w_an           = decode_anode(r_prev[11:8]);
    assign w_digit_commit = w_commit && (w_an.kind == AN_KIND_DIGIT);
    assign w_seen_next    = r_seen | (4'b0001 << w_an.sel);

    sevenseg_decode u_decode (
        .i_seg     (r_prev[7:1]),
        .o_code    (w_code),
        .o_illegal (w_illegal)
    );

    // Synchronizer and stability tracking. armed drops after one commit so a
    // long stable run yields a single commit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_prev     <= '1;
            r_stab_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync1 <= {anode, cathode};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_changed) begin
                r_stab_cnt <= '0;
                r_armed    <= 1'b1;
            end else begin
                if (r_stab_cnt != STAB_MAX) begin
                    r_stab_cnt <= r_stab_cnt + 1'b1;
                end
                if (w_commit) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    // Commit, error pulses and frame tracking.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_digit      <= '{default: '0};
            r_dp         <= '0;
            r_seen       <= '0;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_anode_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_anode_err  <= 1'b0;
            if (w_commit) begin
                case (w_an.kind)
                    AN_KIND_DIGIT: begin
                        r_digit[w_an.sel] <= w_code;
                        r_dp[w_an.sel]    <= ~r_prev[0];
                        r_seg_err         <= w_illegal;
                        // The completing commit belongs to the frame it closes.
                        if (w_seen_next == 4'hF) begin
                            r_seen       <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_seen <= w_seen_next;
                        end
                    end
                    AN_KIND_BAD: r_anode_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Timeout: only digit commits (legal or not) count as bus activity.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_to_cnt <= '0;
            r_stale  <= 1'b1;
        end else if (w_digit_commit) begin
            r_to_cnt <= '0;
            r_stale  <= 1'b0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_MAX - 1'b1) begin
                r_stale <= 1'b1;
            end
        end
    end

    assign ones       = r_digit[0];
    assign tens       = r_digit[1];
    assign hundreds   = r_digit[2];
    assign thousands  = r_digit[3];
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
    assign seg_err    = r_seg_err;
    assign anode_err  = r_anode_err;
    assign stale      = r_stale;

endmodule
